// File: rtl/gen3_lane_scrambler.sv
// PCIe Gen3 128b/130b per-lane transmit scrambler: one registered byte stage that
// applies the data / ordered-set scramble and LFSR-advance rules for each block type.

module gen3_byte_scramble (
    input  logic [22:0] lfsr_in,
    input  logic        adv_disable,
    output logic [22:0] lfsr_out
);

    localparam logic [22:0] POLY_TAPS = 23'h210125;

    // Eight Galois steps of x^23+x^21+x^16+x^8+x^5+x^2+1, i.e. one symbol's worth.
    function automatic logic [22:0] step8(input logic [22:0] s);
        logic [22:0] v;
        v = s;
        for (int i = 0; i < 8; i++) begin
            v = {v[21:0], 1'b0} ^ (v[22] ? POLY_TAPS : 23'h000000);
        end
        return v;
    endfunction

    // Selects the advanced or the held LFSR state.
    always_comb begin
        if (adv_disable) begin
            lfsr_out = lfsr_in;
        end else begin
            lfsr_out = step8(lfsr_in);
        end
    end

endmodule

module gen3_lane_scrambler #(
    parameter logic [23:0] SEED        = 24'h1DBFBC,
    parameter int          BLOCK_BYTES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [1:0] s_sync_hdr,
    input  logic [1:0] s_os_type,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [1:0] m_sync_hdr,
    output logic       m_block_start,
    output logic       m_hdr_err
);

    localparam logic [22:0] SEED23   = SEED[22:0];
    localparam logic [3:0]  LAST_IDX = 4'(BLOCK_BYTES - 1);

    logic [22:0] lfsr_r;
    logic [3:0]  byte_cnt_r;
    logic [1:0]  blk_hdr_r;
    logic [1:0]  blk_type_r;

    logic        accept_s;
    logic        first_s;
    logic        last_s;
    logic [1:0]  cur_hdr_s;
    logic [1:0]  cur_type_s;
    logic        scramble_s;
    logic        advance_s;
    logic        reseed_s;
    logic        hdr_err_s;
    logic [22:0] lfsr_adv_s;
    logic [7:0]  key_s;

    assign s_ready  = !m_valid || m_ready;
    assign accept_s = s_valid && s_ready;
    assign first_s  = (byte_cnt_r == 4'd0);
    assign last_s   = (byte_cnt_r == LAST_IDX);
    assign key_s    = lfsr_r[22:15];

    gen3_byte_scramble u_byte_scramble (
        .lfsr_in     (lfsr_r),
        .adv_disable (1'b0),
        .lfsr_out    (lfsr_adv_s)
    );

    // Per-byte scramble/advance decision; byte 0 decodes the live header inputs.
    always_comb begin
        cur_hdr_s  = first_s ? s_sync_hdr : blk_hdr_r;
        cur_type_s = first_s ? s_os_type  : blk_type_r;
        scramble_s = 1'b0;
        advance_s  = 1'b0;
        reseed_s   = 1'b0;
        hdr_err_s  = 1'b0;
        case (cur_hdr_s)
            2'b10: begin
                scramble_s = 1'b1;
                advance_s  = 1'b1;
            end
            2'b01: begin
                case (cur_type_s)
                    2'b01: begin
                        scramble_s = 1'b0;
                        advance_s  = 1'b0;
                    end
                    2'b10: begin
                        // EIEOS reloads the seed once its final symbol is taken.
                        reseed_s = last_s;
                    end
                    default: begin
                        scramble_s = !first_s;
                        advance_s  = 1'b1;
                    end
                endcase
            end
            default: begin
                hdr_err_s = first_s;
            end
        endcase
    end

    // Output stage, LFSR and block position; all state moves only on an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r        <= SEED23;
            byte_cnt_r    <= 4'd0;
            blk_hdr_r     <= 2'b00;
            blk_type_r    <= 2'b00;
            m_valid       <= 1'b0;
            m_data        <= 8'h00;
            m_sync_hdr    <= 2'b00;
            m_block_start <= 1'b0;
            m_hdr_err     <= 1'b0;
        end else if (accept_s) begin
            m_valid       <= 1'b1;
            m_data        <= s_data ^ (scramble_s ? key_s : 8'h00);
            m_sync_hdr    <= cur_hdr_s;
            m_block_start <= first_s;
            m_hdr_err     <= hdr_err_s;
            if (reseed_s) begin
                lfsr_r <= SEED23;
            end else if (advance_s) begin
                lfsr_r <= lfsr_adv_s;
            end else begin
                lfsr_r <= lfsr_r;
            end
            byte_cnt_r <= last_s ? 4'd0 : byte_cnt_r + 4'd1;
            if (first_s) begin
                blk_hdr_r  <= s_sync_hdr;
                blk_type_r <= s_os_type;
            end else begin
                blk_hdr_r  <= blk_hdr_r;
                blk_type_r <= blk_type_r;
            end
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end else begin
            m_valid <= m_valid;
        end
    end

endmodule

// File: tb/tb_gen3_lane_scrambler.sv
// Table-driven bench for gen3_lane_scrambler: block table with hand-known byte-0
// results, a byte-level reference model feeding a scoreboard, and reset/backpressure sequences.

module tb_gen3_lane_scrambler;

    localparam logic [22:0] SEED23 = 23'h1DBFBC;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [1:0] s_sync_hdr;
    logic [1:0] s_os_type;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [1:0] m_sync_hdr;
    logic       m_block_start;
    logic       m_hdr_err;

    gen3_lane_scrambler dut (
        .clk           (clk),
        .rst           (rst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_sync_hdr    (s_sync_hdr),
        .s_os_type     (s_os_type),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_sync_hdr    (m_sync_hdr),
        .m_block_start (m_block_start),
        .m_hdr_err     (m_hdr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] hdr;
        logic [1:0] ost;
        logic [7:0] base;
        logic       incr;
        logic       chk_b0;
        logic [7:0] exp_b0;
        logic       exp_err;
    } blk_t;

    blk_t        tbl [13];
    int          tests = 0;
    int          fails = 0;
    logic [11:0] exp_q [$];
    logic        throttle = 1'b0;

    logic [22:0] mdl_lfsr;
    logic [3:0]  mdl_cnt;
    logic [1:0]  mdl_hdr;
    logic [1:0]  mdl_typ;

    // Multiply the state by x^8 modulo the scrambler polynomial.
    function automatic logic [22:0] adv8(input logic [22:0] s);
        logic [30:0] t;
        logic [30:0] p;
        t = {s, 8'h00};
        p = {7'd0, 24'hA10125};
        for (int k = 30; k >= 23; k--) begin
            if (t[k]) t = t ^ (p << (k - 23));
        end
        return t[22:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        mdl_lfsr = SEED23;
        mdl_cnt  = 4'd0;
        mdl_hdr  = 2'b00;
        mdl_typ  = 2'b00;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [7:0] d, input logic [1:0] h, input logic [1:0] t);
        logic first, scr, adv, reseed, err;
        first = (mdl_cnt == 4'd0);
        if (first) begin
            mdl_hdr = h;
            mdl_typ = t;
        end
        scr = 1'b0; adv = 1'b0; reseed = 1'b0; err = 1'b0;
        if (mdl_hdr == 2'b10) begin
            scr = 1'b1; adv = 1'b1;
        end else if (mdl_hdr == 2'b01) begin
            if (mdl_typ == 2'b10) reseed = (mdl_cnt == 4'd15);
            else if (mdl_typ != 2'b01) begin scr = !first; adv = 1'b1; end
        end else begin
            err = first;
        end
        exp_q.push_back({d ^ (scr ? mdl_lfsr[22:15] : 8'h00), mdl_hdr, first, err});
        if (reseed) mdl_lfsr = SEED23;
        else if (adv) mdl_lfsr = adv8(mdl_lfsr);
        mdl_cnt = mdl_cnt + 4'd1;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] h, input logic [1:0] t, output int waits);
        logic acc;
        s_data = d; s_sync_hdr = h; s_os_type = t; s_valid = 1'b1;
        waits = 0; acc = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                waits++;
                if (waits > 200) begin
                    check("send_timeout", 32'd0, 32'd1);
                    break;
                end
            end
        end
        s_valid = 1'b0;
        if (acc) model_accept(d, h, t);
    endtask

    task automatic apply_block(input int idx, input logic direct);
        blk_t        b;
        logic [7:0]  d;
        logic [22:0] l1;
        int          w, total;
        b = tbl[idx];
        l1 = adv8(mdl_lfsr);
        total = 0;
        for (int i = 0; i < 16; i++) begin
            d = b.base + (b.incr ? 8'(i) : 8'h00);
            send(d, b.hdr, b.ost, w);
            total += w;
            if (direct) begin
                check($sformatf("latency_b%0d_%0d", idx, i), 32'({m_valid, m_data}),
                      32'({1'b1, exp_q[exp_q.size()-1][11:4]}));
                if (i == 0 && b.chk_b0)
                    check($sformatf("byte0_blk%0d", idx),
                          32'({m_valid, m_data, m_sync_hdr, m_block_start, m_hdr_err}),
                          32'({1'b1, b.exp_b0, b.hdr, 1'b1, b.exp_err}));
                if (i == 1 && b.hdr == 2'b01 && b.ost == 2'b00)
                    check("ts_byte1", 32'(m_data), 32'(d ^ l1[22:15]));
                if (i == 1 && b.exp_err)
                    check("hdr_err_byte1", 32'({m_hdr_err, m_block_start}), 32'd0);
            end
        end
        if (direct) check($sformatf("no_bubble_blk%0d", idx), 32'(total), 32'd0);
    endtask

    // Downstream ready: always high unless throttling is enabled.
    always @(posedge clk) begin
        #1;
        m_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [12:0] held;
    logic        hold_pending = 1'b0;

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && m_valid) begin
            if (hold_pending)
                check("hold_stable", 32'({m_valid, m_data, m_sync_hdr, m_block_start, m_hdr_err}), 32'(held));
            if (m_ready) begin
                if (exp_q.size() == 0) check("unexpected_output", 32'(m_data), 32'hFFFF_FFFF);
                else check("stream", 32'({m_data, m_sync_hdr, m_block_start, m_hdr_err}),
                           32'(exp_q.pop_front()));
            end
        end
        hold_pending = !rst && m_valid && !m_ready;
        held = {m_valid, m_data, m_sync_hdr, m_block_start, m_hdr_err};
    end

    initial begin
        int w;
        tbl[0]  = '{2'b10, 2'b00, 8'h00, 1'b0, 1'b1, 8'h3B, 1'b0};
        tbl[1]  = '{2'b01, 2'b00, 8'h1E, 1'b1, 1'b1, 8'h1E, 1'b0};
        tbl[2]  = '{2'b10, 2'b00, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{2'b01, 2'b01, 8'hAA, 1'b0, 1'b1, 8'hAA, 1'b0};
        tbl[4]  = '{2'b10, 2'b00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[5]  = '{2'b10, 2'b00, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[6]  = '{2'b10, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[7]  = '{2'b01, 2'b10, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        tbl[8]  = '{2'b10, 2'b00, 8'h00, 1'b0, 1'b1, 8'h3B, 1'b0};
        tbl[9]  = '{2'b11, 2'b00, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1};
        tbl[10] = '{2'b01, 2'b11, 8'h30, 1'b1, 1'b1, 8'h30, 1'b0};
        tbl[11] = '{2'b00, 2'b00, 8'h77, 1'b0, 1'b1, 8'h77, 1'b1};
        tbl[12] = '{2'b10, 2'b00, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b0};

        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_sync_hdr = 2'b00; s_os_type = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'({m_valid, m_data, m_sync_hdr, m_block_start, m_hdr_err, s_ready}),
              32'({1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1}));
        rst = 1'b0;
        model_reset();

        // Directed block sequence at full rate.
        for (int k = 0; k < 13; k++) begin
            if (k == 3) tbl[4].exp_b0 = mdl_lfsr[22:15];
            apply_block(k, 1'b1);
        end

        // Reset in the middle of a data block.
        for (int i = 0; i < 7; i++) send(8'h40 + 8'(i), 2'b10, 2'b00, w);
        s_data = 8'h47; s_sync_hdr = 2'b10; s_valid = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_midblock_valid", 32'(m_valid), 32'd0);
        rst = 1'b0; s_valid = 1'b0;
        model_reset();
        send(8'h00, 2'b10, 2'b00, w);
        check("rst_restart_byte0", 32'({m_data, m_block_start, m_sync_hdr}), 32'({8'h3B, 1'b1, 2'b10}));
        for (int i = 1; i < 16; i++) send(8'h00, 2'b10, 2'b00, w);

        // Throttled mixed traffic.
        throttle = 1'b1;
        for (int k = 2; k < 12; k++) apply_block(k, 1'b0);
        throttle = 1'b0;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gen3_lane_scrambler.md
Name: gen3_lane_scrambler

Overview:
- Per-lane PCIe Gen3 128b/130b transmit scrambler. Sits directly downstream of the block framer and upstream of the gearbox.
- Holds the 23-bit scrambler LFSR state and applies the per-symbol scramble/advance rules for each block type.
- Contains one gen3_byte_scramble instance, which provides the 8-bit LFSR advance function.
- Byte-wide valid/ready stream in, byte-wide valid/ready stream out, one registered stage.

Parameters:
- SEED, 24'h1DBFBC, per-lane LFSR seed. Bit 23 is ignored and treated as 0.
- BLOCK_BYTES, 16, symbols per 130-bit block. Fixed at 16; SKP ordered sets are framed as 16 bytes by upstream.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- s_data  in  8  unscrambled symbol
- s_valid  in  1  input symbol valid
- s_ready  out  1  input symbol accepted when s_valid && s_ready
- s_sync_hdr  in  2  sync header; sampled on byte 0 only. 2'b10 = data block, 2'b01 = ordered set block
- s_os_type  in  2  ordered-set type; sampled on byte 0 of an OS block only. 00 = TS/generic, 01 = SKP, 10 = EIEOS, 11 = treated as generic
- m_data  out  8  scrambled symbol
- m_valid  out  1  output valid
- m_ready  in  1  downstream ready
- m_sync_hdr  out  2  sync header of the block the current output byte belongs to
- m_block_start  out  1  current output byte is byte 0 of a block
- m_hdr_err  out  1  sync header on byte 0 was 2'b00 or 2'b11; asserted with that byte's output

Behaviour:
- Reset values: lfsr_q=SEED[22:0], bit 23=0, byte_cnt=0, m_valid=0, m_data=0, m_sync_hdr=0, m_block_start=0, m_hdr_err=0. rst wins over all other events in the same cycle.
- Handshake: s_ready = !m_valid || m_ready (combinational). An accepted input appears on m_* the next cycle, so latency is 1.
- m_valid drops when m_ready is high and there is no accept. Output is held stable while m_valid && !m_ready.
- Key = lfsr_q[22:15], i.e. key[i] = lfsr_q[15+i].
- Scrambled byte = s_data ^ key. Unscrambled byte = s_data passthrough.
- LFSR advance: lfsr_q <= advance(lfsr_q), using gen3_byte_scramble with disable=0. Bit 23 is always written 0. Advance happens only on an accept.
- byte_cnt counts accepted bytes 0..15 and wraps to 0 after 15.
  - On byte 0: latch blk_hdr=s_sync_hdr and blk_type=s_os_type. Byte 0 uses the live inputs; bytes 1-15 use the latched values.
- Per-byte rules:
  - Data block (hdr 10): every byte scrambled and advanced.
  - OS generic/TS (hdr 01, type 00/11): byte 0 unscrambled but advanced; bytes 1-15 scrambled and advanced.
  - SKP (hdr 01, type 01): no byte scrambled, no advance.
  - EIEOS (hdr 01, type 10): no byte scrambled, no advance. On the accept of byte 15, lfsr_q <= SEED.
  - Invalid header (00/11): bytes pass unscrambled with no advance. m_hdr_err=1 on byte 0 only. Block boundary tracking continues.
- m_sync_hdr is the block header on every output byte. m_block_start=1 only for byte 0.
- Backpressure: no state changes without an accept. The LFSR and byte_cnt freeze while stalled.
- Reset mid-block: the next accepted byte is treated as byte 0 and the LFSR restarts from SEED.

Test Plan:
- Reset, then a data block (hdr 10) of 16 zero bytes with m_ready=1.
  - Byte 0 outputs 8'h3B with m_block_start=1 and m_sync_hdr=10.
  - Bytes 1-15 equal the successive key bytes from the advance model.
  - Output stream has 1-cycle latency and no bubbles.
- TS block (hdr 01, type 00) of bytes 8'h1E..: byte 0 outputs 8'h1E unchanged; byte 1 = s_data ^ key of an LFSR advanced once from its block-start state.
- SKP block between two data blocks: all 16 SKP bytes pass unchanged. The key of the following data block's byte 0 equals the key the SKP block's byte 0 would have used.
- EIEOS block mid-stream after 3 data blocks, followed by a data block of zeros: EIEOS bytes pass unchanged, and the next block's byte 0 outputs 8'h3B.
- Random m_ready throttling (~50%) over 10 mixed blocks.
  - m_* hold stable while stalled.
  - Output matches the reference model byte-for-byte; no drops or duplicates.
- Byte 0 with hdr 2'b11: m_hdr_err=1 on that byte only, no scrambling. Additionally, assert rst at byte 7 of a data block: m_valid=0 next cycle, and the next accept yields a byte 0 keyed from SEED.
